mds_mult_sequencer: RTL and testbench

- Computes the Twofish MDS matrix-vector product z = MDS · y over GF(2^8), with polynomial 0x169.
- Time-multiplexes a single instance of the team's combinational GF(2^8) multiplier, whose ports are 8-bit A, 8-bit B, 9-bit polynomial P and 8-bit Out. It performs one byte product per clock.
- Sits after the q-permutation/key-XOR stage of the h-function in the iterative datapath.
- Uses a start/busy/done handshake toward the round controller.

---
 rtl/mds_mult_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mds_mult_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mds_mult_sequencer.sv
// Twofish MDS (optionally RS, via `RS_SUPPORT_EN) matrix-vector product,
// one GF(2^8) byte product per clock through a shared multiplier.

module gf256_mul (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [8:0] p_i,
    output logic [7:0] y_o
);

    logic [7:0] acc;
    logic [7:0] sh;
    logic [8:0] t;

    always_comb begin
        acc = '0;
        sh  = a_i;
        t   = '0;
        for (int i = 0; i < 8; i++) begin
            if (b_i[i]) acc = acc ^ sh;
            t = {sh, 1'b0};
            if (t[8]) t = t ^ p_i;
            sh = t[7:0];
        end
        y_o = acc;
    end

endmodule

module mds_mult_sequencer #(
    parameter logic [8:0] POLY_MDS = 9'h169
`ifdef RS_SUPPORT_EN
    ,
    parameter logic [8:0] POLY_RS  = 9'h14D
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef RS_SUPPORT_EN
    input  logic        mode,
    input  logic [63:0] din,
`else
    input  logic [31:0] din,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] dout
);

`ifdef RS_SUPPORT_EN
    localparam int KW = 5;
    localparam int DW = 64;
`else
    localparam int KW = 4;
    localparam int DW = 32;
`endif

    localparam logic [0:15][7:0] MDS_ROM = {
        8'h01, 8'hEF, 8'h5B, 8'h5B,
        8'h5B, 8'hEF, 8'hEF, 8'h01,
        8'hEF, 8'h5B, 8'h01, 8'hEF,
        8'hEF, 8'h01, 8'hEF, 8'h5B
    };

`ifdef RS_SUPPORT_EN
    localparam logic [0:31][7:0] RS_ROM = {
        8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E,
        8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5,
        8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19,
        8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03
    };
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [DW-1:0]    vec_q, vec_d;
    logic [3:0][7:0]  acc_q, acc_d, acc_nx;
    logic [31:0]      dout_q, dout_d;
    logic             done_q, done_d;

    logic [1:0]       row;
    logic [7:0]       coef;
    logic [7:0]       ybyte;
    logic [8:0]       poly;
    logic [7:0]       prod;
    logic             last;
    logic             accept;

`ifdef RS_SUPPORT_EN
    logic             mode_q, mode_d;
    logic [2:0]       col;

    // MDS requests keep the 4x4 walk even on the wider counter
    always_comb begin
        row   = mode_q ? k_q[4:3] : k_q[3:2];
        col   = mode_q ? k_q[2:0] : {1'b0, k_q[1:0]};
        last  = mode_q ? (k_q == 5'd31) : (k_q == 5'd15);
        poly  = mode_q ? POLY_RS : POLY_MDS;
        coef  = mode_q ? RS_ROM[{row, col}] : MDS_ROM[{row, col[1:0]}];
        ybyte = vec_q[8*col +: 8];
    end
`else
    logic [1:0]       col;

    always_comb begin
        row   = k_q[3:2];
        col   = k_q[1:0];
        last  = &k_q;
        poly  = POLY_MDS;
        coef  = MDS_ROM[{row, col}];
        ybyte = vec_q[8*col +: 8];
    end
`endif

    gf256_mul u_mul (
        .a_i (coef),
        .b_i (ybyte),
        .p_i (poly),
        .y_o (prod)
    );

    // A start on the finishing edge restarts at once, so a held start
    // yields one result every 16 (or 32) clocks.
    assign accept = start && ((state_q == IDLE) || last);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        vec_d   = vec_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
`ifdef RS_SUPPORT_EN
        mode_d  = mode_q;
`endif
        acc_nx      = acc_q;
        acc_nx[row] = acc_q[row] ^ prod;
        unique case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                acc_d = acc_nx;
                k_d   = k_q + KW'(1);
                if (last) begin
                    dout_d  = acc_nx;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        if (accept) begin
            state_d = RUN;
            vec_d   = din;
            acc_d   = '0;
            k_d     = '0;
`ifdef RS_SUPPORT_EN
            mode_d  = mode;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            vec_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
`ifdef RS_SUPPORT_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            vec_q   <= vec_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
`ifdef RS_SUPPORT_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_mds_mult_sequencer.sv
// Scoreboard bench for mds_mult_sequencer; reference model computes the
// matrix product directly with GF(2^8) arithmetic.

module tb_mds_mult_sequencer;

`ifdef RS_SUPPORT_EN
    localparam int DW = 64;
    logic mode = 1'b0;
`else
    localparam int DW = 32;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] din   = '0;
    logic          busy;
    logic          done;
    logic [31:0]   dout;

    mds_mult_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef RS_SUPPORT_EN
        .mode  (mode),
`endif
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_accept = 0;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    int mds_t[4][4] = '{'{'h01, 'hEF, 'h5B, 'h5B},
                        '{'h5B, 'hEF, 'hEF, 'h01},
                        '{'hEF, 'h5B, 'h01, 'hEF},
                        '{'hEF, 'h01, 'hEF, 'h5B}};
    int rs_t[4][8] = '{'{'h01, 'hA4, 'h55, 'h87, 'h5A, 'h58, 'hDB, 'h9E},
                       '{'hA4, 'h56, 'h82, 'hF3, 'h1E, 'hC6, 'h68, 'hE5},
                       '{'h02, 'hA1, 'hFC, 'hC1, 'h47, 'hAE, 'h3D, 'h19},
                       '{'hA4, 'h55, 'h87, 'h5A, 'h58, 'hDB, 'h9E, 'h03}};

    function automatic logic [7:0] gmul(input int a, input int b, input int p);
        int r = 0;
        while (b != 0) begin
            if ((b & 1) != 0) r = r ^ a;
            a = a << 1;
            if ((a & 'h100) != 0) a = a ^ p;
            b = b >> 1;
        end
        return r[7:0];
    endfunction

    function automatic logic [31:0] ref_model(input logic [63:0] v, input bit m);
        logic [31:0] z = '0;
        for (int i = 0; i < 4; i++) begin
            if (m) begin
                for (int j = 0; j < 8; j++)
                    z[8*i +: 8] = z[8*i +: 8] ^ gmul(rs_t[i][j], int'(v[8*j +: 8]), 'h14D);
            end else begin
                for (int j = 0; j < 4; j++)
                    z[8*i +: 8] = z[8*i +: 8] ^ gmul(mds_t[i][j], int'(v[8*j +: 8]), 'h169);
            end
        end
        return z;
    endfunction

    // Monitor: pops on every done, and checks dout stays put otherwise.
    logic [31:0] last_dout = '0;
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_done: dout=%h at cycle %0d, required no done", dout, cyc);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e.val || cyc != e.due) begin
                    errors++;
                    $display("FAIL result: dout=%h at cycle %0d, required %h at cycle %0d",
                             dout, cyc, e.val, e.due);
                end
            end
        end else if (rst_n) begin
            checks++;
            if (dout !== last_dout) begin
                errors++;
                $display("FAIL dout_hold: dout=%h without done, required %h", dout, last_dout);
            end
        end
        last_dout = dout;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic issue(input logic [63:0] v, input bit m, input logic [31:0] expv,
                         input bit use_model);
        int n = 0;
        exp_t e;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: busy=%b, required 0", busy);
        end
        din = v[DW-1:0];
`ifdef RS_SUPPORT_EN
        mode = m;
`endif
        start = 1'b1;
        last_accept = cyc + 1;
        e.val = use_model ? ref_model(v, m) : expv;
        e.due = last_accept + (m ? 32 : 16);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        din = DW'({$urandom, $urandom});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc != c && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int n;
        exp_t e;
        logic [63:0] v;
        bit m;

        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dout", 64'(dout), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(64'h1, 1'b0, 32'hEFEF5B01, 1'b0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 64'(n), 64'd16);
        drain();

        issue(64'h100, 1'b0, 32'h015BEFEF, 1'b0);
        drain();
        issue(64'h0, 1'b0, 32'h00000000, 1'b0);
        drain();

        issue(64'h1, 1'b0, 32'hEFEF5B01, 1'b0);
        a = last_accept;
        wait_cyc(a + 2);
        start = 1'b1;
        din = DW'({$urandom, $urandom});
        @(negedge clk);
        start = 1'b0;
        wait_cyc(a + 9);
        start = 1'b1;
        din = DW'({$urandom, $urandom});
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        din = DW'(1);
        start = 1'b1;
        a = cyc + 1;
        for (int i = 1; i <= 4; i++) begin
            e.val = 32'hEFEF5B01;
            e.due = a + 16 * i;
            exp_q.push_back(e);
        end
        wait_cyc(a + 48);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        issue({$urandom, $urandom}, 1'b0, 32'h0, 1'b1);
        a = last_accept;
        wait_cyc(a + 6);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_dout", 64'(dout), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(64'h1, 1'b0, 32'hEFEF5B01, 1'b0);
        drain();

`ifdef RS_SUPPORT_EN
        issue(64'h1, 1'b1, 32'hA402A401, 1'b0);
        drain();
        issue(64'h1, 1'b0, 32'hEFEF5B01, 1'b0);
        drain();
`endif

        for (int t = 0; t < 24; t++) begin
            v = {$urandom, $urandom};
`ifdef RS_SUPPORT_EN
            m = 1'($urandom_range(0, 1));
`else
            m = 1'b0;
`endif
            issue(v, m, 32'h0, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                drain();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
